// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard-unit bus; master drives decoder/EX status, slave returns pipeline controls and counters.
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 32);
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic id_halt;
  logic ex_memread;
  logic [4:0] ex_rd;
  logic ex_redirect;
  logic pc_write;
  logic ifid_write;
  logic ifid_flush;
  logic idex_flush;
  logic halted;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_cycles;
  modport master (
    output id_rs1, id_rs2, id_halt, ex_memread, ex_rd, ex_redirect,
    input pc_write, ifid_write, ifid_flush, idex_flush, halted, stall_cycles, flush_cycles
  );
  modport slave (
    input id_rs1, id_rs2, id_halt, ex_memread, ex_rd, ex_redirect,
    output pc_write, ifid_write, ifid_flush, idex_flush, halted, stall_cycles, flush_cycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use stall, redirect squash and halt-drain sequencing for a 5-stage pipeline.
// Optional saturating stall/flush counters are built only when PERF_COUNTERS_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic reset,
  pipeline_hazard_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic halted_q, halted_d;
  logic load_use, run, take_halt, drain_done;
  assign load_use = bus.ex_memread && bus.ex_rd != 5'd0 &&
                    (bus.ex_rd == bus.id_rs1 || bus.ex_rd == bus.id_rs2);
  assign run = state_q == RUN;
  assign take_halt = run && !bus.ex_redirect && !load_use && bus.id_halt;
  assign drain_done = state_q == DRAIN && cnt_q == 4'd0;
  // redirect overrides both stall sources, so a squashed halt never freezes fetch
  assign bus.pc_write = run && (bus.ex_redirect || !(load_use || bus.id_halt));
  assign bus.ifid_write = bus.pc_write;
  assign bus.ifid_flush = run && bus.ex_redirect;
  assign bus.idex_flush = !run || bus.ex_redirect || load_use;
  assign bus.halted = halted_q;
  always_comb begin
    state_d = take_halt ? DRAIN : drain_done ? HALTED : state_q;
    cnt_d = take_halt ? 4'(DRAIN_CYCLES - 1) : (state_q == DRAIN && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    halted_d = halted_q || drain_done;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q <= 4'd0;
      halted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      halted_q <= halted_d;
    end
  end
`ifdef PERF_COUNTERS_EN
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  always_comb begin
    stall_d = (run && !bus.ex_redirect && load_use && !(&stall_q)) ? stall_q + 1'b1 : stall_q;
    flush_d = (run && bus.ex_redirect && !(&flush_q)) ? flush_q + 1'b1 : flush_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end
  assign bus.stall_cycles = stall_q;
  assign bus.flush_cycles = flush_q;
`else
  assign bus.stall_cycles = '0;
  assign bus.flush_cycles = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed scoreboard bench driving a DRAIN_CYCLES=3 and a DRAIN_CYCLES=1 instance in lockstep.
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int exp_stall = 0;
  int exp_flush = 0;
  typedef struct {
    logic [3:0] ctl;
    logic ha;
    logic hb;
  } exp_t;
  exp_t sb[$];
  pipeline_hazard_ctrl_if #(.CNT_W(32)) bus_a ();
  pipeline_hazard_ctrl_if #(.CNT_W(32)) bus_b ();
  pipeline_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(32)) u_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
  pipeline_hazard_ctrl #(.DRAIN_CYCLES(1), .CNT_W(32)) u_b (.clk(clk), .reset(reset), .bus(bus_b.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic halt,
                       input logic mr, input logic [4:0] rd, input logic redir);
    bus_a.id_rs1 = rs1; bus_a.id_rs2 = rs2; bus_a.id_halt = halt;
    bus_a.ex_memread = mr; bus_a.ex_rd = rd; bus_a.ex_redirect = redir;
    bus_b.id_rs1 = rs1; bus_b.id_rs2 = rs2; bus_b.id_halt = halt;
    bus_b.ex_memread = mr; bus_b.ex_rd = rd; bus_b.ex_redirect = redir;
  endtask
  task automatic compare_now(input string tag);
    exp_t e;
    e = sb.pop_front();
    chk({tag, "_ctl_a"}, {60'd0, bus_a.pc_write, bus_a.ifid_write, bus_a.ifid_flush, bus_a.idex_flush}, {60'd0, e.ctl});
    chk({tag, "_ctl_b"}, {60'd0, bus_b.pc_write, bus_b.ifid_write, bus_b.ifid_flush, bus_b.idex_flush}, {60'd0, e.ctl});
    chk({tag, "_halted_a"}, {63'd0, bus_a.halted}, {63'd0, e.ha});
    chk({tag, "_halted_b"}, {63'd0, bus_b.halted}, {63'd0, e.hb});
  endtask
  // ctl expectation packs {pc_write, ifid_write, ifid_flush, idex_flush}
  task automatic step(input string tag, input logic [4:0] rs1, input logic [4:0] rs2, input logic halt,
                      input logic mr, input logic [4:0] rd, input logic redir,
                      input logic [3:0] ctl, input logic ha, input logic hb);
    @(posedge clk);
    #1;
    drive(rs1, rs2, halt, mr, rd, redir);
    sb.push_back('{ctl: ctl, ha: ha, hb: hb});
    @(negedge clk);
    compare_now(tag);
  endtask
  task automatic chk_cnt(input string tag);
    logic [31:0] es, ef;
`ifdef PERF_COUNTERS_EN
    es = 32'(exp_stall);
    ef = 32'(exp_flush);
`else
    es = 32'd0;
    ef = 32'd0;
`endif
    chk({tag, "_stall_a"}, {32'd0, bus_a.stall_cycles}, {32'd0, es});
    chk({tag, "_flush_a"}, {32'd0, bus_a.flush_cycles}, {32'd0, ef});
    chk({tag, "_stall_b"}, {32'd0, bus_b.stall_cycles}, {32'd0, es});
    chk({tag, "_flush_b"}, {32'd0, bus_b.flush_cycles}, {32'd0, ef});
  endtask
  initial begin
    drive(0, 0, 0, 0, 0, 0);
    #2;
    sb.push_back('{ctl: 4'b1100, ha: 1'b0, hb: 1'b0});
    compare_now("reset");
    chk_cnt("reset");
    @(posedge clk);
    #1 reset = 1'b0;
    step("idle", 0, 0, 0, 0, 0, 0, 4'b1100, 0, 0);
    step("lu_rs1", 5, 1, 0, 1, 5, 0, 4'b0001, 0, 0);
    exp_stall++;
    step("lu_after", 6, 5, 0, 0, 0, 0, 4'b1100, 0, 0);
    chk_cnt("lu_rs1");
    step("rd0", 0, 0, 0, 1, 0, 0, 4'b1100, 0, 0);
    step("rd0_b", 0, 3, 0, 1, 0, 0, 4'b1100, 0, 0);
    step("lu_rs2", 3, 7, 0, 1, 7, 0, 4'b0001, 0, 0);
    exp_stall++;
    step("no_match", 3, 4, 0, 1, 7, 0, 4'b1100, 0, 0);
    step("redir_halt", 0, 0, 1, 0, 0, 1, 4'b1111, 0, 0);
    exp_flush++;
    step("after_redir", 0, 0, 0, 0, 0, 0, 4'b1100, 0, 0);
    step("redir_lu", 9, 0, 0, 1, 9, 1, 4'b1111, 0, 0);
    exp_flush++;
    chk_cnt("mixed");
    step("halt_lu", 8, 0, 1, 1, 8, 0, 4'b0001, 0, 0);
    exp_stall++;
    step("halt_acc", 8, 0, 1, 0, 0, 0, 4'b0000, 0, 0);
    step("drain1", 4, 0, 1, 1, 4, 1, 4'b0001, 0, 0);
    step("drain2", 4, 0, 0, 1, 4, 1, 4'b0001, 0, 1);
    step("drain3", 0, 0, 1, 0, 0, 1, 4'b0001, 0, 1);
    step("halted", 0, 0, 0, 0, 0, 0, 4'b0001, 1, 1);
    for (int i = 0; i < 20; i++)
      step("halted_hold", 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), 1'($urandom),
           4'b0001, 1, 1);
    chk_cnt("frozen");
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    exp_stall = 0;
    exp_flush = 0;
    step("halt2_acc", 0, 0, 1, 0, 0, 0, 4'b0000, 0, 0);
    step("halt2_drain1", 0, 0, 0, 0, 0, 0, 4'b0001, 0, 0);
    #2 reset = 1'b1;
    #1;
    sb.push_back('{ctl: 4'b1100, ha: 1'b0, hb: 1'b0});
    compare_now("async_rst");
    chk_cnt("async_rst");
    #9 reset = 1'b0;
    step("post_rst", 0, 0, 0, 0, 0, 0, 4'b1100, 0, 0);
    step("halt3_acc", 0, 0, 1, 0, 0, 0, 4'b0000, 0, 0);
    step("halt3_d1", 0, 0, 0, 0, 0, 0, 4'b0001, 0, 0);
    step("halt3_d2", 0, 0, 0, 0, 0, 0, 4'b0001, 0, 1);
    step("halt3_d3", 0, 0, 0, 0, 0, 0, 4'b0001, 0, 1);
    step("halt3_done", 0, 0, 0, 0, 0, 0, 4'b0001, 1, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Sequences the 5-stage RISC-V pipeline around the main decoder. Detects load-use hazards and inserts one bubble. Squashes wrong-path instructions on a taken branch, JAL or JALR resolved in EX. Runs a halt-drain state machine: on a Halt opcode in ID it freezes fetch, lets older instructions retire, then latches a sticky halted status.

Parameters:
DRAIN_CYCLES, 3, cycles spent in DRAIN after halt acceptance (EX, MEM, WB retire); legal range 1..15
CNT_W, 32, width of the performance counters (used only with PERF_COUNTERS_EN)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
id_rs1  input  5  rs1 field of the instruction in ID
id_rs2  input  5  rs2 field of the instruction in ID
id_halt  input  1  decoder Halt for the instruction in ID
ex_memread  input  1  MemRead of the instruction in EX (ID/EX register)
ex_rd  input  5  destination register of the instruction in EX
ex_redirect  input  1  taken branch, JAL or JALR resolved in EX this cycle
pc_write  output  1  PC update enable
ifid_write  output  1  IF/ID register load enable
ifid_flush  output  1  clear IF/ID to NOP
idex_flush  output  1  clear ID/EX control bits (bubble)
halted  output  1  sticky halt status
stall_cycles  output  CNT_W  load-use stall cycle count
flush_cycles  output  CNT_W  redirect flush cycle count

Behaviour:
- Reset is asynchronous. While reset is high and after release: state=RUN, drain counter=0, halted=0, counters=0. Outputs take RUN idle values: pc_write=1, ifid_write=1, ifid_flush=0, idex_flush=0.
- Control outputs are combinational from state and inputs. State, counter and halted are registered.
- load_use = ex_memread && ex_rd!=0 && (ex_rd==id_rs1 || ex_rd==id_rs2).
- RUN priority is redirect > load_use > halt > idle:
  - redirect: ifid_flush=1, idex_flush=1, pc_write=1, ifid_write=1. Any id_halt that cycle is squashed and not accepted.
  - load_use: pc_write=0, ifid_write=0, idex_flush=1 for exactly one cycle. A halt in ID waits and is accepted only once the stall clears.
  - halt accepted (id_halt, no redirect, no load_use) in cycle T: pc_write=0, ifid_write=0, idex_flush=0, so the halt moves to EX. Next state is DRAIN with counter=DRAIN_CYCLES-1.
  - idle: pass-through values.
- DRAIN:
  - pc_write=0, ifid_write=0, idex_flush=1, ifid_flush=0.
  - Counter decrements each cycle; at 0 the next state is HALTED.
  - ex_redirect and load_use are ignored.
  - DRAIN occupies cycles T+1 .. T+DRAIN_CYCLES.
- HALTED:
  - halted=1 from cycle T+DRAIN_CYCLES+1 onward.
  - pc_write=0, ifid_write=0, idex_flush=1.
  - All inputs ignored; only reset exits.
- Reset asserted mid-DRAIN or in HALTED returns immediately to RUN idle values.
- ex_rd==0 never causes a stall, even when rs1 or rs2 is x0.

Optional Feature:
PERF_COUNTERS_EN
- Defined: stall_cycles increments in every RUN cycle where load_use wins arbitration. flush_cycles increments in every RUN cycle where redirect is asserted. Both saturate at all-ones, clear on reset, and freeze in DRAIN and HALTED.
- Not defined: both outputs are tied to 0 and no counter flops are built.

Test Plan:
- lw x5 then add x6,x5,x1 (ex_memread=1, ex_rd=5, id_rs1=5) -> exactly one cycle of pc_write=0, ifid_write=0, idex_flush=1; next cycle idle; stall_cycles=1 with the macro.
- ex_memread=1, ex_rd=0, id_rs1=0 -> no stall; pc_write=1 throughout.
- ex_redirect=1 with id_halt=1 in the same cycle -> ifid_flush=idex_flush=1; no DRAIN entry; halted stays 0; flush_cycles=1.
- id_halt=1 at cycle T with load_use=1 -> stall at T; halt accepted at T+1; DRAIN at T+2..T+4; halted=1 at T+5 (DRAIN_CYCLES=3).
- DRAIN_CYCLES=1, halt accepted at T -> DRAIN only at T+1; halted=1 at T+2 and held for 20 cycles regardless of inputs.
- Assert reset for one cycle during DRAIN, asynchronously mid-cycle -> outputs return to pc_write=1, halted=0 at once; a fresh halt afterwards drains normally.
